// File: rtl/usb_crc_pkg.sv
// Shared types, constants and the bit-serial CRC update used by the USB CRC stream engine.
package usb_crc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StData   = 2'd1;
    localparam state_t StAppend = 2'd2;
    localparam state_t StDone   = 2'd3;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [4:0]  CRC5_POLY  = 5'h05;

    function automatic logic [31:0] crc_mask(input int unsigned width);
        logic [63:0] m;
        m = (64'd1 << width) - 64'd1;
        return m[31:0];
    endfunction

    // Shift-register update over data_w bits; reflect selects LSB-first bit order.
    function automatic logic [31:0] crc_step(
        input logic [31:0] crc_in,
        input logic [31:0] data,
        input logic [31:0] poly,
        input int unsigned crc_w,
        input int unsigned data_w,
        input logic        reflect
    );
        logic [31:0] c;
        logic        fb;
        logic        b;
        c = crc_in;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < data_w) begin
                b  = reflect ? data[5'(i)] : data[5'(data_w - 1 - i)];
                fb = c[5'(crc_w - 1)] ^ b;
                c  = c << 1;
                if (fb) begin
                    c = c ^ poly;
                end
            end
        end
        return c & crc_mask(crc_w);
    endfunction

    function automatic logic [31:0] crc_reflect(input logic [31:0] v, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                r[5'(i)] = v[5'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_crc_stream_if.sv
// Valid/ready beat stream with a frame-end marker.
interface usb_crc_stream_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
    logic              ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/usb_crc_fifo.sv
// Shallow shift buffer holding the trailing CRC beats of a check-mode frame.
module usb_crc_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    output logic                     full,
    output logic [DATA_W-1:0]        head,
    output logic [DEPTH*DATA_W-1:0]  contents
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q;

    assign full = (count_q == CNT_W'(DEPTH));
    assign head = mem_q[0];

    // Entry 0 is the oldest beat and lands in the least-significant position.
    always_comb begin
        contents = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            contents[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            count_q <= '0;
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
                mem_q[DEPTH-1] <= push_data;
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CNT_W'(i) == count_q) begin
                        mem_q[i] <= push_data;
                    end
                end
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/usb_crc_stream.sv
// Streaming CRC engine: appends the CRC in generate mode, strips and verifies it in check mode.
module usb_crc_stream
    import usb_crc_pkg::*;
#(
    parameter int unsigned        CRC_W   = 16,
    parameter int unsigned        DATA_W  = 8,
    parameter logic [CRC_W-1:0]   POLY    = CRC_W'(CRC16_POLY),
    parameter logic [CRC_W-1:0]   INIT    = '1,
    parameter logic [CRC_W-1:0]   XOR_OUT = '1,
    parameter bit                 REFLECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  mode,
    usb_crc_stream_if.slave       in_if,
    usb_crc_stream_if.master      out_if,
    output logic [CRC_W-1:0]      crc_value,
    output logic                  crc_done,
    output logic                  crc_ok,
    output logic                  crc_short
);
    localparam int unsigned N_CRC = (CRC_W + DATA_W - 1) / DATA_W;
    localparam int unsigned PAD_W = N_CRC * DATA_W;
    localparam int unsigned CNT_W = $clog2(N_CRC + 1);

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic                payload_q, payload_d;
    logic [CNT_W-1:0]    app_cnt_q, app_cnt_d;
    logic                ready_en_q;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [CRC_W-1:0]    crc_value_q, crc_value_d;
    logic                crc_done_q, crc_done_d;
    logic                crc_ok_q, crc_ok_d;
    logic                crc_short_q, crc_short_d;

    logic                can_load;
    logic                in_ready;
    logic                accept;
    logic                frame_mode;
    logic [CRC_W-1:0]    crc_base;
    logic [DATA_W-1:0]   step_data;
    logic [CRC_W-1:0]    crc_upd;
    logic [CRC_W-1:0]    crc_final;
    logic [PAD_W-1:0]    crc_pad;
    logic                fifo_push;
    logic                fifo_flush;
    logic                fifo_full;
    logic [DATA_W-1:0]   fifo_head;
    logic [PAD_W-1:0]    fifo_contents;

    usb_crc_fifo #(
        .DEPTH  (N_CRC),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (in_if.data),
        .full      (fifo_full),
        .head      (fifo_head),
        .contents  (fifo_contents)
    );

    always_comb begin
        can_load   = !out_valid_q || out_if.ready;
        in_ready   = ready_en_q && !clear && can_load &&
                     ((state_q == StIdle) || (state_q == StData));
        accept     = in_ready && in_if.valid;
        frame_mode = (state_q == StIdle) ? mode : mode_q;
        crc_base   = (state_q == StIdle) ? INIT : crc_q;
        // Check mode only folds in the beat that falls out of the CRC delay line.
        step_data  = frame_mode ? fifo_head : in_if.data;
        crc_upd    = CRC_W'(crc_step(32'(crc_base), 32'(step_data), 32'(POLY), CRC_W, DATA_W,
                                     REFLECT));
        crc_final  = (REFLECT ? CRC_W'(crc_reflect(32'(crc_q), CRC_W)) : crc_q) ^ XOR_OUT;
        crc_pad    = PAD_W'(crc_final);
        fifo_push  = accept && frame_mode;
        fifo_flush = clear || (state_q == StDone);
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        crc_d       = crc_q;
        payload_d   = payload_q;
        app_cnt_d   = app_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        crc_value_d = crc_value_q;
        crc_ok_d    = crc_ok_q;
        crc_short_d = crc_short_q;
        crc_done_d  = 1'b0;

        if (out_if.ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle, StData: begin
                if (accept) begin
                    if (state_q == StIdle) begin
                        mode_d    = mode;
                        payload_d = 1'b0;
                        crc_d     = INIT;
                        state_d   = StData;
                    end
                    if (!frame_mode) begin
                        crc_d       = crc_upd;
                        out_data_d  = in_if.data;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        if (in_if.last) begin
                            state_d   = StAppend;
                            app_cnt_d = '0;
                        end
                    end else begin
                        if (fifo_full) begin
                            crc_d       = crc_upd;
                            out_data_d  = fifo_head;
                            out_valid_d = 1'b1;
                            out_last_d  = in_if.last;
                            payload_d   = 1'b1;
                        end
                        if (in_if.last) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StAppend: begin
                if (can_load) begin
                    out_data_d  = DATA_W'(crc_pad >> (32'(app_cnt_q) * DATA_W));
                    out_valid_d = 1'b1;
                    if (app_cnt_q == CNT_W'(N_CRC - 1)) begin
                        out_last_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        out_last_d = 1'b0;
                        app_cnt_d  = app_cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                crc_done_d  = 1'b1;
                crc_value_d = crc_final;
                if (mode_q) begin
                    crc_short_d = !payload_q;
                    crc_ok_d    = payload_q && (fifo_contents == crc_pad);
                end else begin
                    crc_short_d = 1'b0;
                    crc_ok_d    = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any transfer or result update this cycle.
        if (clear) begin
            state_d     = StIdle;
            crc_d       = INIT;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            crc_done_d  = 1'b0;
            crc_value_d = crc_value_q;
            crc_ok_d    = crc_ok_q;
            crc_short_d = crc_short_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            crc_q       <= INIT;
            payload_q   <= 1'b0;
            app_cnt_q   <= '0;
            ready_en_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            crc_value_q <= '0;
            crc_done_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            crc_q       <= crc_d;
            payload_q   <= payload_d;
            app_cnt_q   <= app_cnt_d;
            ready_en_q  <= 1'b1;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            crc_value_q <= crc_value_d;
            crc_done_q  <= crc_done_d;
            crc_ok_q    <= crc_ok_d;
            crc_short_q <= crc_short_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.data  = out_data_q;
    assign out_if.valid = out_valid_q;
    assign out_if.last  = out_last_q;
    assign crc_value    = crc_value_q;
    assign crc_done     = crc_done_q;
    assign crc_ok       = crc_ok_q;
    assign crc_short    = crc_short_q;

endmodule
